// File: rtl/if_stage.sv
// Instruction fetch stage. Keeps at most one fetch in flight on the SRAM-like port,
// hands instructions to ID and follows branch, exception and ertn redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        wb_is_ertn,
  input  logic [31:0] era,
  input  logic        id_allowin,
  output logic        if_ready_go,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_ex_adef
);
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] buf_reg;
  logic [31:0] pend_target_reg;
  logic [1:0]  pend_rank_reg;
  logic        discard_reg;

  logic [1:0]  rd_rank;
  logic [31:0] rd_target;
  logic        redirect_now;
  logic        take_new;
  logic [1:0]  sel_rank;
  logic [31:0] sel_target;
  logic [31:0] next_pc;
  logic        pc_misaligned;
  logic        inst_valid;

  // Rank encodes redirect priority: 3 exception, 2 ertn, 1 branch, 0 none.
  always_comb begin
    rd_rank   = 2'd0;
    rd_target = br_target;
    if (wb_ex) begin
      rd_rank   = 2'd3;
      rd_target = ex_entry;
    end else if (wb_is_ertn) begin
      rd_rank   = 2'd2;
      rd_target = era;
    end else if (br_taken) begin
      rd_rank   = 2'd1;
    end
  end

  assign redirect_now  = (rd_rank != 2'd0);
  assign take_new      = redirect_now && (rd_rank >= pend_rank_reg);
  assign sel_rank      = take_new ? rd_rank : pend_rank_reg;
  assign sel_target    = take_new ? rd_target : pend_target_reg;
  assign next_pc       = (sel_rank != 2'd0) ? sel_target : (pc_reg + 32'd4);
  assign pc_misaligned = (pc_reg[1:0] != 2'b00);
  assign inst_valid    = ((state_reg == S_WAIT) && inst_sram_data_ok && !discard_reg) ||
                         (state_reg == S_HOLD) || (state_reg == S_ERR);

  assign inst_sram_req  = !rst && (state_reg == S_REQ) && !pc_misaligned;
  assign inst_sram_addr = pc_reg;
  // Any redirect in the current cycle marks the presented instruction as wrong-path.
  assign if_ready_go    = !rst && inst_valid && id_allowin && !redirect_now;
  assign if_pc          = rst ? RESET_PC : pc_reg;
  assign if_ex_adef     = !rst && (state_reg == S_ERR);

  always_comb begin
    if_inst = 32'h0;
    if (!rst) begin
      if (state_reg == S_HOLD)
        if_inst = buf_reg;
      else if ((state_reg == S_WAIT) && !discard_reg)
        if_inst = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      buf_reg         <= 32'h0;
      pend_target_reg <= 32'h0;
      pend_rank_reg   <= 2'd0;
      discard_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (pc_misaligned) begin
            if (redirect_now)
              pc_reg <= rd_target;
            else
              state_reg <= S_ERR;
          end else if (inst_sram_addr_ok) begin
            state_reg <= S_WAIT;
            // Request left with the old pc: its data must be dropped later.
            if (redirect_now) begin
              discard_reg     <= 1'b1;
              pend_rank_reg   <= rd_rank;
              pend_target_reg <= rd_target;
            end
          end else if (redirect_now) begin
            pc_reg <= rd_target;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            if (discard_reg || redirect_now || id_allowin) begin
              pc_reg        <= next_pc;
              state_reg     <= S_REQ;
              discard_reg   <= 1'b0;
              pend_rank_reg <= 2'd0;
            end else begin
              buf_reg   <= inst_sram_rdata;
              state_reg <= S_HOLD;
            end
          end else if (redirect_now) begin
            discard_reg <= 1'b1;
            if (take_new) begin
              pend_rank_reg   <= rd_rank;
              pend_target_reg <= rd_target;
            end
          end
        end
        default: begin
          if (redirect_now || id_allowin) begin
            pc_reg    <= next_pc;
            state_reg <= S_REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL provide ports: inst_sram_req  out  1  fetch request; inst_sram_addr  out  32  fetch address; inst_sram_addr_ok  in  1  request accepted; inst_sram_data_ok  in  1  read data valid; inst_sram_rdata  in  32  read data.
REQ-003 SHALL provide ports: br_taken  in  1  ID branch redirect; br_target  in  32  branch target; wb_ex  in  1  exception flush; ex_entry  in  32  exception entry; wb_is_ertn  in  1  ertn flush; era  in  32  return address.
REQ-004 SHALL provide ports: id_allowin  in  1  ID accepts; if_ready_go  out  1  transfer strobe to ID register; if_pc  out  32  fetched PC; if_inst  out  32  fetched instruction; if_ex_adef  out  1  fetch-address-error flag.
REQ-005 SHALL use parameter RESET_PC, default 32'h1c000000, first fetch address.

Function
REQ-006 SHALL hold fetch PC register pc; inst_sram_addr SHALL equal pc while inst_sram_req is high.
REQ-007 SHALL implement FSM states REQ, WAIT, HOLD, ERR.
REQ-008 REQ: inst_sram_req=1; on addr_ok -> WAIT; addr_ok absent -> stay in REQ, pc and addr held stable.
REQ-009 WAIT: inst_sram_req=0; on data_ok with id_allowin=1 -> present rdata, if_ready_go=1 same cycle, pc<=next_pc, -> REQ.
REQ-010 WAIT: on data_ok with id_allowin=0 -> capture rdata into buffer, -> HOLD.
REQ-011 HOLD: output buffered inst; when id_allowin=1 -> if_ready_go=1, pc<=next_pc, -> REQ.
REQ-012 if_ready_go SHALL be high only in cycles where a valid instruction is transferred (valid && id_allowin); never high otherwise.
REQ-013 next_pc priority: wb_ex -> ex_entry; wb_is_ertn -> era; br_taken -> br_target; else pc+4 (32-bit wrap, carry discarded).
REQ-014 Redirect (wb_ex/wb_is_ertn/br_taken) SHALL be recorded in a pending-redirect register when it arrives in a cycle where pc cannot be updated; the pending target SHALL be used at the next pc update and then cleared; a later higher-priority redirect overwrites it.
REQ-015 Redirect in REQ before addr_ok: pc<=target immediately, stay REQ, no stale fetch.
REQ-016 Redirect while in WAIT: set discard flag; the next data_ok SHALL be dropped (no if_ready_go), then pc<=target, -> REQ.
REQ-017 Redirect while in HOLD: buffered inst dropped, pc<=target, -> REQ same cycle.
REQ-018 wb_ex/wb_is_ertn SHALL suppress if_ready_go in the same cycle.
REQ-019 If pc[1:0]!=0 on entering REQ, SHALL not assert inst_sram_req; -> ERR; ERR presents if_inst=0, if_ex_adef=1, transfers on id_allowin, then pc<=next_pc, -> REQ.
REQ-020 if_ex_adef SHALL be 0 for every aligned fetch.
REQ-021 At most one request SHALL be outstanding; no new req while in WAIT.
REQ-022 if_pc SHALL equal the PC of the instruction presented with if_ready_go.

Reset
REQ-023 On rst: pc=RESET_PC, state=REQ, discard=0, pending-redirect=0, buffer=0.
REQ-024 During rst: inst_sram_req=0, if_ready_go=0, if_ex_adef=0, if_inst=0, if_pc=RESET_PC.
REQ-025 rst mid-WAIT SHALL clear discard; a data_ok arriving after rst deassert with no request issued SHALL be ignored.

Verification
REQ-026 Reset release, addr_ok and data_ok each 1 cycle late, id_allowin=1 -> first if_ready_go with if_pc=0x1c000000, second with 0x1c000004.
REQ-027 data_ok with id_allowin=0 for 3 cycles, rdata=0x02800401 -> if_ready_go low 3 cycles, then high with if_inst=0x02800401; no new req before transfer.
REQ-028 br_taken, br_target=0x1c000100 while in WAIT -> returning data dropped, next req addr=0x1c000100.
REQ-029 wb_ex, ex_entry=0x1c008000 same cycle as br_taken to 0x1c000200 -> next fetch addr 0x1c008000.
REQ-030 br_target=0x1c000102 -> no inst_sram_req, if_ready_go with if_pc=0x1c000102, if_ex_adef=1, if_inst=0.
REQ-031 rst asserted in WAIT, stale data_ok after release -> no if_ready_go; fetch restarts at 0x1c000000.
